// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_pkg
// Brief   : Shared response codes, FSM state types and word-shift constant.
// Revision: 1.0
// ============================================================================
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte address to 32-bit word index.
  localparam int unsigned WORD_SHIFT = 2;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_addr_decode.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_addr_decode
// Brief   : Byte address to register index, with alignment and range check.
// Revision: 1.0
// ============================================================================
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              NUM_REGS  = 16,
  parameter int              IDX_W     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_word;

  // Offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land far out of range.
  assign w_off  = i_addr - BASE_ADDR;
  assign w_word = w_off >> WORD_SHIFT;
  assign o_hit  = (w_off[1:0] == 2'b00) && (w_word < ADDR_W'(NUM_REGS));
  assign o_idx  = w_word[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_slave_regfile
// Brief   : AXI4-lite responder backed by a local 32-bit register bank.
// Revision: 1.0
// ============================================================================
module axi_lite_slave_regfile
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [3:0]                 wstrb,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [ADDR_W-1:0]          araddr,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NBYTES = 4;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  w_state_t          r_wstate, w_wstate_nxt;
  logic              r_aw_cap, r_w_cap;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp;

  r_state_t          r_rstate, w_rstate_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_W-1:0] w_aw_addr;
  logic [DATA_W-1:0] w_wdata_eff;
  logic [3:0]        w_wstrb_eff;
  logic              w_aw_hit, w_ar_hit;
  logic [IDX_W-1:0]  w_aw_idx, w_ar_idx;

  assign awready = !rst && (r_wstate == W_IDLE) && !r_aw_cap;
  assign wready  = !rst && (r_wstate == W_IDLE) && !r_w_cap;
  assign arready = !rst && (r_rstate == R_IDLE);
  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = r_bresp;
  assign rvalid  = (r_rstate == R_DATA);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  // A half captured earlier merges with the other half arriving this cycle.
  assign w_aw_addr   = r_aw_cap ? r_awaddr : awaddr;
  assign w_wdata_eff = r_w_cap  ? r_wdata  : wdata;
  assign w_wstrb_eff = r_w_cap  ? r_wstrb  : wstrb;
  assign w_commit    = (r_wstate == W_IDLE) && (r_aw_cap || w_aw_hs) && (r_w_cap || w_w_hs);

  axi_lite_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_aw_decode (
    .i_addr(w_aw_addr),
    .o_hit (w_aw_hit),
    .o_idx (w_aw_idx)
  );

  axi_lite_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_ar_decode (
    .i_addr(araddr),
    .o_hit (w_ar_hit),
    .o_idx (w_ar_idx)
  );

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (bready)   w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (rready)  w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_aw_cap <= 1'b0;
      r_w_cap  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_aw_cap <= 1'b1;
        r_awaddr <= awaddr;
      end
      if (w_w_hs) begin
        r_w_cap <= 1'b1;
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      // Flags clear at commit; readies stay low through W_RESP via the state term.
      if (w_commit) begin
        r_aw_cap <= 1'b0;
        r_w_cap  <= 1'b0;
        r_bresp  <= w_aw_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_aw_hit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (w_wstrb_eff[b]) r_regs[w_aw_idx][8*b +: 8] <= w_wdata_eff[8*b +: 8];
      end
    end
  end

  // Reading r_regs here sees the pre-commit value when a write lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_ar_hit ? r_regs[w_ar_idx] : '0;
        r_rresp <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_slave_regfile
// Brief   : Directed self-checking bench for axi_lite_slave_regfile.
// Revision: 1.0
// ============================================================================
module tb_axi_lite_slave_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] regs_flat;
  logic [511:0] exp_flat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_lite_slave_regfile #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_flat(regs_flat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    exp_flat = '0;
    tick(); tick();
    n_cmp++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ready_low: got %b want 000", {awready, wready, arready});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_bad++; $display("FAIL reset_idle: got %b want 11100", {awready, wready, arready, bvalid, rvalid});
    end
    n_cmp++;
    if (regs_flat !== exp_flat) begin
      n_bad++; $display("FAIL reset_regs: got %h want 0", regs_flat);
    end
  endtask

  task automatic test_basic_write_read();
    awvalid = 1; awaddr = 32'h4; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1;
    tick();
    awvalid = 0; wvalid = 0;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_bad++; $display("FAIL basic_bresp: got bvalid=%b bresp=%b want 1/00", bvalid, bresp);
    end
    tick();
    exp_flat[63:32] = 32'hDEADBEEF;
    n_cmp++;
    if (bvalid !== 1'b0 || regs_flat !== exp_flat) begin
      n_bad++; $display("FAIL basic_commit: got bvalid=%b reg1=%h want 0/deadbeef", bvalid, regs_flat[63:32]);
    end
    bready = 0;
    arvalid = 1; araddr = 32'h4; rready = 0;
    tick();
    arvalid = 0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
      n_bad++; $display("FAIL basic_read: got rvalid=%b rdata=%h rresp=%b want 1/deadbeef/00", rvalid, rdata, rresp);
    end
    rready = 1;
    tick();
    rready = 0;
    n_cmp++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_bad++; $display("FAIL basic_read_done: got rvalid=%b arready=%b want 0/1", rvalid, arready);
    end
  endtask

  task automatic test_w_before_aw();
    bready = 1;
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'b0101;
    tick();
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wready !== 1'b0 || bvalid !== 1'b0) begin
        n_bad++; $display("FAIL wfirst_hold[%0d]: got wready=%b bvalid=%b want 0/0", i, wready, bvalid);
      end
      if (i < 2) tick();
    end
    awvalid = 1; awaddr = 32'h8;
    tick();
    awvalid = 0;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wready !== 1'b0) begin
      n_bad++; $display("FAIL wfirst_resp: got bvalid=%b bresp=%b wready=%b want 1/00/0", bvalid, bresp, wready);
    end
    tick();
    exp_flat[95:64] = 32'h00220044;
    n_cmp++;
    if (regs_flat !== exp_flat || bvalid !== 1'b0) begin
      n_bad++; $display("FAIL wfirst_reg2: got reg2=%h bvalid=%b want 00220044/0", regs_flat[95:64], bvalid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] bad_addr [2];
    bad_addr[0] = 32'h40;
    bad_addr[1] = 32'h6;
    bready = 1;
    for (int i = 0; i < 2; i++) begin
      awvalid = 1; awaddr = bad_addr[i]; wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
      tick();
      awvalid = 0; wvalid = 0;
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b10) begin
        n_bad++; $display("FAIL err_bresp(%h): got bvalid=%b bresp=%b want 1/10", bad_addr[i], bvalid, bresp);
      end
      tick();
      n_cmp++;
      if (regs_flat !== exp_flat) begin
        n_bad++; $display("FAIL err_nochange(%h): got %h want %h", bad_addr[i], regs_flat, exp_flat);
      end
    end
    bready = 0;
    arvalid = 1; araddr = 32'h40;
    tick();
    arvalid = 0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b10) begin
      n_bad++; $display("FAIL err_read: got rvalid=%b rdata=%h rresp=%b want 1/00000000/10", rvalid, rdata, rresp);
    end
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic test_backpressure();
    bready = 0;
    awvalid = 1; awaddr = 32'h0; wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    awaddr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      awvalid = 1;
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
        n_bad++; $display("FAIL bp_b[%0d]: got bvalid=%b bresp=%b awready=%b want 1/00/0", i, bvalid, bresp, awready);
      end
      tick();
    end
    awvalid = 0;
    bready = 1;
    tick();
    bready = 0;
    exp_flat[31:0] = 32'h12345678;
    n_cmp++;
    if (bvalid !== 1'b0 || regs_flat !== exp_flat) begin
      n_bad++; $display("FAIL bp_b_done: got bvalid=%b reg0=%h want 0/12345678", bvalid, regs_flat[31:0]);
    end
    arvalid = 1; araddr = 32'h0;
    tick();
    arvalid = 0; araddr = 32'h4;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== 32'h12345678 || arready !== 1'b0) begin
        n_bad++; $display("FAIL bp_r[%0d]: got rvalid=%b rdata=%h arready=%b want 1/12345678/0", i, rvalid, rdata, arready);
      end
      tick();
    end
    rready = 1;
    tick();
    rready = 0;
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_bad++; $display("FAIL bp_r_done: got rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_same_edge_and_reset();
    bready = 0; rready = 0;
    awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    arvalid = 1; araddr = 32'hC;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_flat[127:96] = 32'hA5A5A5A5;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || bvalid !== 1'b1) begin
      n_bad++; $display("FAIL same_edge_old: got rvalid=%b rdata=%h bvalid=%b want 1/00000000/1", rvalid, rdata, bvalid);
    end
    n_cmp++;
    if (regs_flat !== exp_flat) begin
      n_bad++; $display("FAIL same_edge_reg3: got reg3=%h want a5a5a5a5", regs_flat[127:96]);
    end
    rready = 1;
    tick();
    rready = 0;
    arvalid = 1; araddr = 32'hC;
    tick();
    arvalid = 0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL same_edge_new: got rvalid=%b rdata=%h want 1/a5a5a5a5", rvalid, rdata);
    end
    rready = 1;
    tick();
    rready = 0;
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_bvalid: got %b want 1", bvalid);
    end
    rst = 1;
    tick();
    exp_flat = '0;
    n_cmp++;
    if (bvalid !== 1'b0 || regs_flat !== exp_flat || rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_in_resp: got bvalid=%b reg3=%h rdata=%h want 0/0/0", bvalid, regs_flat[127:96], rdata);
    end
    rst = 0;
    tick();
    n_cmp++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      n_bad++; $display("FAIL post_reset_idle: got %b want 1110", {awready, wready, arready, bvalid});
    end
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_w_before_aw();
    test_errors();
    test_backpressure();
    test_same_edge_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
AXI4-lite responder that terminates both the write channels (AW/W/B) and the read channel (AR/R) in a local bank of 32-bit registers. It does not pass accesses through to external memory. It is the register-bank endpoint that hangs off the master side of our AXI4-lite interconnect for control/status registers. The full register bank is exported flat so downstream logic can consume register values directly.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, data width; fixed at 32 (wstrb is 4 bits)
NUM_REGS, 16, number of registers; valid byte offsets are 0 to 4*NUM_REGS-4
BASE_ADDR, 32'h0000_0000, byte address of register 0

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_W  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_W  write data
wstrb  in  4  byte enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response; 2'b00 OKAY, 2'b10 SLVERR
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_W  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_W  read data
rresp  out  2  read response; 2'b00 OKAY, 2'b10 SLVERR
regs_flat  out  NUM_REGS*DATA_W  register contents; register i occupies bits [32i+31:32i]

Behaviour:
- Reset (rst high at a clk edge):
  - All registers, bvalid and rvalid go to 0; bresp, rresp and rdata go to 0.
  - awready, wready and arready are 0 while rst is high.
  - Any in-flight transaction is discarded; no response is issued for it.
- Address decode:
  - off = addr - BASE_ADDR, computed modulo 2^ADDR_W.
  - The access is valid when off[1:0]==0 and off>>2 < NUM_REGS; idx = off>>2.
  - Any other address is an error: SLVERR, no register write, rdata=0.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: awready = !aw_captured and wready = !w_captured. AW and W are accepted independently, in either order or in the same cycle. Address and data/strobe are latched on their respective handshakes.
  - When both are captured (including within the same cycle), the register update is committed on that edge and the FSM enters W_RESP.
  - Register update: for each b in 0..3, if wstrb[b], reg[idx][8b+7:8b] = wdata[8b+7:8b]. wstrb==0 is OKAY with no change.
  - W_RESP: bvalid=1, bresp held stable, awready=wready=0. On bvalid&&bready, return to W_IDLE with the capture flags cleared.
  - Minimum latency: bvalid is asserted the cycle after the later of the AW and W handshakes.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid, rdata and rresp are sampled from the registers at that edge and the FSM enters R_DATA.
  - R_DATA: arready=0, rvalid=1, rdata/rresp held stable until rvalid&&rready, then return to R_IDLE.
  - Read latency is 1 cycle from the AR handshake; the peak rate is one read per 2 cycles.
- Simultaneous events:
  - If a write commit and an AR handshake fall on the same edge to the same register, the read returns the old value.
  - Read and write FSMs are fully independent; stalling on one channel never blocks the other.
- regs_flat is a direct register output, updated on the commit edge (visible the following cycle).
- Protocol: outputs never depend combinationally on a valid/ready input within the same cycle, except for the capture-flag gating described above.

Decomposition:
- Shared package axi_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - state encodings W_IDLE/W_RESP and R_IDLE/R_DATA
  - the 4-byte word-shift constant
- One natural sub-module, axi_lite_addr_decode: combinational mapping addr -> {hit, idx}. It is instantiated twice, once for AW and once for AR.
- The register bank and both FSMs stay in the top module.

Test Plan:
1. Reset then idle -> awready=wready=arready=1 the cycle after rst drops; bvalid=rvalid=0; regs_flat=0.
2. AW 0x4 and W 0xDEADBEEF, wstrb 4'hF in the same cycle, bready=1 -> bvalid next cycle with bresp=00. A subsequent AR 0x4 returns rdata=0xDEADBEEF, rresp=00, with rvalid one cycle after arready&&arvalid.
3. W ahead of AW by 3 cycles (wdata 0x11223344, wstrb 4'b0101), then AW 0x8 -> reg2 becomes 0x00220044. wready stays 0 after the W handshake until B completes.
4. AW 0x40 (out of range for NUM_REGS=16) or 0x6 (misaligned) -> bresp=10 and no register changes. AR 0x40 -> rdata=0, rresp=10.
5. Backpressure: bready=0 for 5 cycles -> bvalid and bresp stay stable and awready=0 throughout. rready=0 for 5 cycles -> rvalid and rdata stay stable.
6. Same-edge write commit to reg3 (0xA5A5A5A5 over 0x0) and AR 0xC -> rdata=0x00000000; the next read returns 0xA5A5A5A5. Asserting rst during W_RESP -> bvalid=0 next cycle and reg3 becomes 0.
